// File: rtl/ahb_copy_master.sv
// AHB-Lite word-copy initiator: reads a block of 32-bit words from a source
// address and writes them to a destination, one NONSEQ transfer at a time.
module ahb_copy_master #(
    parameter int AW = 32,
    parameter int LW = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_WADDR,
        S_LAST,
        S_ERR
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t        state_reg, state_next;
    logic [AW-1:0] src_ptr_reg, src_ptr_next;
    logic [AW-1:0] dst_ptr_reg, dst_ptr_next;
    logic [LW-1:0] rem_reg, rem_next;
    logic [31:0]   wbuf_reg, wbuf_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    // Set while a write data phase is outstanding; the first read after
    // accept has no data phase to take an error from.
    logic          wr_pend_reg, wr_pend_next;

    // Byte-offset bits of the command addresses are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cmd_src[1:0], cmd_dst[1:0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg   <= S_IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            rem_reg     <= '0;
            wbuf_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            wr_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            src_ptr_reg <= src_ptr_next;
            dst_ptr_reg <= dst_ptr_next;
            rem_reg     <= rem_next;
            wbuf_reg    <= wbuf_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            wr_pend_reg <= wr_pend_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_ptr_next = src_ptr_reg;
        dst_ptr_next = dst_ptr_reg;
        rem_next     = rem_reg;
        wbuf_next    = wbuf_reg;
        done_next    = 1'b0;
        err_next     = err_reg;
        wr_pend_next = wr_pend_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_ptr_next = {cmd_src[AW-1:2], 2'b00};
                    dst_ptr_next = {cmd_dst[AW-1:2], 2'b00};
                    rem_next     = cmd_len;
                    err_next     = 1'b0;
                    wr_pend_next = 1'b0;
                    if (cmd_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (wr_pend_reg && HRESP && !HREADY) begin
                    state_next = S_ERR;
                    err_next   = 1'b1;
                end else if (HREADY) begin
                    src_ptr_next = src_ptr_reg + AW'(4);
                    wr_pend_next = 1'b0;
                    state_next   = S_WADDR;
                end
            end
            S_WADDR: begin
                if (HRESP && !HREADY) begin
                    state_next = S_ERR;
                    err_next   = 1'b1;
                end else if (HREADY) begin
                    wbuf_next    = HRDATA;
                    dst_ptr_next = dst_ptr_reg + AW'(4);
                    rem_next     = rem_reg - LW'(1);
                    wr_pend_next = 1'b1;
                    state_next   = (rem_reg == LW'(1)) ? S_LAST : S_RADDR;
                end
            end
            S_LAST: begin
                if (HRESP && !HREADY) begin
                    state_next = S_ERR;
                    err_next   = 1'b1;
                end else if (HREADY) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            S_ERR: begin
                // HTRANS is already IDLE here, cancelling the stalled address phase.
                if (HREADY) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        HTRANS = TRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = '0;
        case (state_reg)
            S_RADDR: begin
                HTRANS = TRANS_NONSEQ;
                HADDR  = src_ptr_reg;
            end
            S_WADDR: begin
                HTRANS = TRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = dst_ptr_reg;
            end
            default: begin
                HTRANS = TRANS_IDLE;
            end
        endcase
    end

    assign HWDATA    = wbuf_reg;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Self-checking bench for ahb_copy_master: an AHB slave with wait-state and
// error injection, plus a word-level reference of what each copy must do.
`timescale 1ns/1ps
module tb_ahb_copy_master;

    localparam int AW = 32;
    localparam int LW = 16;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy, done, err;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [31:0]   HWDATA, HRDATA;
    logic          HREADY, HRESP;

    ahb_copy_master #(.AW(AW), .LW(LW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- AHB slave model ----------------
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic w; logic [31:0] addr; } ap_t;

    logic [31:0] mem [0:1023];
    wr_t         wr_q[$];
    ap_t         ap_q[$];
    logic        dp_valid, dp_write, dp_err, err_stage;
    logic [31:0] dp_addr;
    int          wait_left;
    int          rd_waits = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    assign HREADY = !dp_valid ? 1'b1 : (dp_err ? err_stage : (wait_left == 0));
    assign HRESP  = dp_valid && dp_err;
    assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_err    <= 1'b0;
            err_stage <= 1'b0;
            dp_addr   <= '0;
            wait_left <= 0;
        end else if (HREADY) begin
            if (dp_valid && dp_write && !dp_err) wr_q.push_back('{dp_addr, HWDATA});
            dp_valid  <= (HTRANS == 2'b10);
            dp_write  <= HWRITE;
            dp_addr   <= HADDR;
            wait_left <= (HTRANS == 2'b10 && !HWRITE) ? rd_waits : 0;
            dp_err    <= (HTRANS == 2'b10) && !HWRITE && err_en && (HADDR == err_addr);
            err_stage <= 1'b0;
        end else if (dp_err) begin
            err_stage <= 1'b1;
        end else begin
            wait_left <= wait_left - 1;
        end
    end

    // ---------------- checking helpers ----------------
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_haddr;
    logic [1:0]  prev_htrans;
    logic        prev_hwrite;

    logic [1:0]  tr_htrans [0:303];
    logic [31:0] tr_haddr  [0:303];
    logic        tr_hwrite [0:303];
    logic [31:0] tr_hwdata [0:303];
    logic        tr_busy   [0:303];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, then observe the bus.
    task automatic tick();
        @(negedge HCLK);
        if (prev_stall) begin
            chk("stall_haddr", 64'(HADDR), 64'(prev_haddr));
            chk("stall_htrans", 64'(HTRANS), 64'(prev_htrans));
            chk("stall_hwrite", 64'(HWRITE), 64'(prev_hwrite));
        end
        prev_stall  = !HRESET && (HTRANS == 2'b10) && !HREADY && !HRESP;
        prev_haddr  = HADDR;
        prev_htrans = HTRANS;
        prev_hwrite = HWRITE;
        if (!HRESET && HTRANS == 2'b10 && HREADY) ap_q.push_back('{HWRITE, HADDR});
        if (!HRESET && done) done_cnt++;
    endtask

    task automatic fill_src(input logic [31:0] src, input int len);
        logic [31:0] a;
        a = {src[31:2], 2'b00};
        for (int i = 0; i < len; i++) mem[(a[11:2] + 10'(i))] = $urandom;
    endtask

    // Presents a command on the current falling edge and runs until done.
    task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int waits, input bit keep_valid, output int done_at);
        ap_q.delete();
        wr_q.delete();
        rd_waits  = waits;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        chk("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
        done_at = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 1) begin
                if (keep_valid) begin
                    cmd_src = $urandom;
                    cmd_dst = $urandom;
                    cmd_len = LW'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            tr_htrans[n] = HTRANS;
            tr_haddr[n]  = HADDR;
            tr_hwrite[n] = HWRITE;
            tr_hwdata[n] = HWDATA;
            tr_busy[n]   = busy;
            if (done) begin
                done_at   = n;
                cmd_valid = 1'b0;
                break;
            end
        end
        chk("done_seen", 64'(done_at > 0), 64'd1);
    endtask

    // Reference: word i of src lands at dst+4i; 2 cycles per word plus the
    // read wait states, plus the LAST cycle and the done cycle.
    task automatic verify(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int waits, input int done_at);
        logic [31:0] sa, da, exp_a;
        int          exp_done;
        sa = {src[31:2], 2'b00};
        da = {dst[31:2], 2'b00};
        exp_done = (len == 0) ? 1 : (2 * len + 2 + waits * len);
        chk({name, "_done_at"}, 64'(done_at), 64'(exp_done));
        chk({name, "_err"}, 64'(err), 64'd0);
        chk({name, "_ready_on_done"}, 64'(cmd_ready), 64'd1);
        chk({name, "_naddr"}, 64'(ap_q.size()), 64'(2 * len));
        for (int i = 0; i < len && 2 * i + 1 < ap_q.size(); i++) begin
            exp_a = sa + 32'(4 * i);
            chk({name, "_raddr"}, 64'(ap_q[2 * i]), {31'd0, 1'b0, exp_a});
            exp_a = da + 32'(4 * i);
            chk({name, "_waddr"}, 64'(ap_q[2 * i + 1]), {31'd0, 1'b1, exp_a});
        end
        chk({name, "_nwrites"}, 64'(wr_q.size()), 64'(len));
        for (int i = 0; i < len && i < wr_q.size(); i++) begin
            exp_a = sa + 32'(4 * i);
            chk({name, "_wdata"}, 64'(wr_q[i]), {da + 32'(4 * i), mem[exp_a[11:2]]});
        end
        if (len > 0 && done_at > 1) begin
            exp_a = sa + 32'(4 * (len - 1));
            chk({name, "_last_hwdata"}, 64'(tr_hwdata[done_at - 1]), 64'(mem[exp_a[11:2]]));
            chk({name, "_last_idle"}, 64'(tr_htrans[done_at - 1]), 64'd0);
            chk({name, "_busy"}, 64'(tr_busy[1]), 64'd1);
        end
        if (len == 0) chk({name, "_no_bus"}, 64'(tr_htrans[1]), 64'd0);
        if (waits == 0 && len > 0 && done_at == exp_done) begin
            for (int n = 1; n <= 2 * len; n++) begin
                exp_a = (n % 2 == 1) ? sa + 32'(4 * ((n - 1) / 2)) : da + 32'(4 * (n / 2 - 1));
                chk({name, "_cyc_htrans"}, 64'(tr_htrans[n]), 64'd2);
                chk({name, "_cyc_haddr"}, 64'(tr_haddr[n]), 64'(exp_a));
                chk({name, "_cyc_hwrite"}, 64'(tr_hwrite[n]), 64'(n % 2 == 0));
            end
        end
        $display("copy %s src=%0h dst=%0h len=%0d waits=%0d done_at=%0d", name, src, dst, len, waits, done_at);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d, dc, len, waits;
        logic [31:0] src, dst;

        for (int i = 0; i < 3; i++) tick();
        HRESET = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwrite", 64'(HWRITE), 64'd0);
        chk("rst_hwdata", 64'(HWDATA), 64'd0);
        chk("hsize", 64'(HSIZE), 64'd2);
        chk("hburst", 64'(HBURST), 64'd0);
        chk("hprot", 64'(HPROT), 64'd3);
        $display("reset state checked");
        tick();

        // Zero-wait copy, then done must not repeat.
        fill_src(32'h100, 4);
        do_copy(32'h100, 32'h200, 4, 0, 1'b0, d);
        verify("zero_wait", 32'h100, 32'h200, 4, 0, d);
        dc = done_cnt;
        tick();
        chk("zero_wait_done_once", 64'(done), 64'd0);
        tick();
        chk("zero_wait_done_cnt", 64'(done_cnt), 64'(dc));

        // Two wait states on every read data phase.
        fill_src(32'h100, 4);
        do_copy(32'h100, 32'h200, 4, 2, 1'b0, d);
        verify("wait2", 32'h100, 32'h200, 4, 2, d);
        tick();

        do_copy(32'h100, 32'h200, 0, 0, 1'b0, d);
        verify("zero_len", 32'h100, 32'h200, 0, 0, d);
        tick();

        // Error on the read of 0x104.
        fill_src(32'h100, 4);
        err_en   = 1'b1;
        err_addr = 32'h104;
        do_copy(32'h100, 32'h200, 4, 0, 1'b0, d);
        err_en = 1'b0;
        chk("rderr_done_at", 64'(d), 64'd6);
        chk("rderr_err", 64'(err), 64'd1);
        chk("rderr_c1_htrans", 64'(tr_htrans[4]), 64'd2);
        chk("rderr_c1_hwrite", 64'(tr_hwrite[4]), 64'd1);
        chk("rderr_c1_haddr", 64'(tr_haddr[4]), 64'h204);
        chk("rderr_c2_htrans", 64'(tr_htrans[5]), 64'd0);
        chk("rderr_naddr", 64'(ap_q.size()), 64'd3);
        chk("rderr_nwrites", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("rderr_write0", 64'(wr_q[0]), {32'h200, mem[10'h040]});
        $display("read error copy done_at=%0d err=%0b", d, err);
        tick();
        tick();
        chk("rderr_err_sticky", 64'(err), 64'd1);
        fill_src(32'h300, 1);
        do_copy(32'h300, 32'h400, 1, 0, 1'b0, d);
        verify("after_err", 32'h300, 32'h400, 1, 0, d);
        tick();

        // Reset while in WADDR.
        fill_src(32'h100, 4);
        cmd_src = 32'h100; cmd_dst = 32'h200; cmd_len = LW'(4); cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("midrst_in_waddr", 64'(HWRITE), 64'd1);
        dc = done_cnt;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("midrst_htrans", 64'(HTRANS), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_no_done", 64'(done_cnt), 64'(dc));
        $display("reset mid-copy checked");
        fill_src(32'h100, 1);
        do_copy(32'h100, 32'h200, 1, 0, 1'b0, d);
        verify("post_rst", 32'h100, 32'h200, 1, 0, d);
        tick();

        // Unaligned addresses, second command on the done cycle.
        fill_src(32'h100, 1);
        do_copy(32'h103, 32'h2FE, 1, 0, 1'b0, d);
        verify("unaligned", 32'h103, 32'h2FE, 1, 0, d);
        fill_src(32'h500, 2);
        do_copy(32'h500, 32'h600, 2, 0, 1'b0, d);
        verify("back2back", 32'h500, 32'h600, 2, 0, d);
        tick();

        // Random copies; cmd_valid held with junk fields while busy.
        for (int r = 0; r < 8; r++) begin
            len   = $urandom_range(1, 6);
            waits = $urandom_range(0, 3);
            src   = 32'h400 + 32'($urandom_range(0, 255));
            dst   = 32'h800 + 32'($urandom_range(0, 255));
            fill_src(src, len);
            do_copy(src, dst, len, waits, 1'b1, d);
            verify("random", src, dst, len, waits, d);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_copy_master.md
Name: ahb_copy_master

Overview:
- Single-channel AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address.
- Acts as the bus-master counterpart to the on-chip SRAM responder, and serves as the data-mover core of the DMA subsystem.
- Accepts one command at a time on a valid/ready interface.
- Issues single NONSEQ word transfers, with each write address phase overlapping the preceding read data phase (2 cycles/word at zero wait states).
- Reports completion and bus errors.

Parameters:
- AW, 32: HADDR/command address width.
- LW, 16: command length width, in words.

Ports:
- HCLK  in  1  system bus clock
- HRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle; command accepted when cmd_valid & cmd_ready
- cmd_src  in  AW  source byte address (bits [1:0] ignored)
- cmd_dst  in  AW  destination byte address (bits [1:0] ignored)
- cmd_len  in  LW  number of words to copy
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag for the last command
- HADDR  out  AW  AHB address
- HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
- HWRITE  out  1  AHB write
- HSIZE  out  3  constant 3'b010
- HBURST  out  3  constant 3'b000
- HPROT  out  4  constant 4'b0011
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready (from interconnect)
- HRESP  in  1  AHB error response

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is synchronous, active-high. All state updates on the rising edge of HCLK.
- Reset values: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0, cmd_ready=1.
- Reset mid-operation: the engine returns to IDLE on the next edge. Any in-flight transfer is abandoned; no done pulse is issued.
- cmd_ready=1 only in IDLE. busy = !IDLE.
- On accept:
  - latch src_ptr={cmd_src[AW-1:2],2'b00}, dst_ptr likewise, rem=cmd_len; clear err.
  - If cmd_len==0: done=1 in the next cycle, stay IDLE, no bus activity.
  - Otherwise go to RADDR.
- State IDLE: HTRANS=IDLE.
- State RADDR: HTRANS=NONSEQ, HWRITE=0, HADDR=src_ptr.
  - The previous word's write data phase may be concurrent; HWDATA=wbuf.
  - On HREADY=1: src_ptr+=4, go to WADDR.
- State WADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=dst_ptr. The read data phase is concurrent.
  - On HREADY=1: wbuf<=HRDATA, dst_ptr+=4, rem-=1.
  - If rem==1, go to LAST; else go to RADDR.
- State LAST: HTRANS=IDLE; final write data phase, HWDATA=wbuf.
  - On HREADY=1: go to IDLE with done=1 for one cycle.
- Address/control stability: HADDR, HTRANS, and HWRITE are held stable while HREADY=0. HWDATA is held stable through the entire write data phase.
- Pointer arithmetic: pointers wrap modulo 2^AW, with no boundary checks. rem is LW bits wide; the maximum copy is 2^LW-1 words.
- Error handling:
  - Trigger: HRESP=1 & HREADY=0 (first error cycle) in any data phase, i.e. the read data phase in WADDR, or a write data phase in RADDR or LAST.
  - On the trigger, go to ERR and set err=1.
  - In ERR: HTRANS=IDLE, which cancels the pending unaccepted address phase. wbuf is not updated, and no further transfers are issued.
  - On HREADY=1 in ERR: go to IDLE with done=1.
  - err stays high until the next command is accepted.
- Simultaneous events:
  - cmd_valid is ignored while busy.
  - HRESP=1 together with HREADY=1 (a protocol violation) is treated as OKAY.

Test Plan:
- Zero-wait copy: cmd_src=0x100, cmd_dst=0x200, cmd_len=4, source words A0..A3.
  - HTRANS is NONSEQ for 8 consecutive cycles, with addresses 0x100, 0x200, 0x104, 0x204, ….
  - The write data phase for 0x20C carries A3 in the LAST cycle.
  - done pulses exactly once, 10 cycles after accept. err=0.
- Wait states: same command, HREADY=0 for 2 cycles in every read data phase.
  - HADDR, HTRANS, and HWRITE remain frozen during the stalls.
  - Destination receives A0..A3 in order.
  - Total duration is 8 cycles longer than the zero-wait case.
- Zero length: cmd_len=0.
  - done=1 one cycle after accept; HTRANS stays IDLE; cmd_ready is back to 1 immediately.
- Read error on the second word: HRESP=1 in the 0x104 read data phase.
  - Cycle 1 of the error response: HTRANS=NONSEQ, HWRITE=1, HADDR=0x204 held.
  - Cycle 2 of the error response: HTRANS=IDLE.
  - done=1 with err=1; only 0x200 is written.
  - The next command clears err.
- Reset mid-copy: assert HRESET for 1 cycle while in WADDR.
  - Next cycle: HTRANS=IDLE, busy=0, cmd_ready=1, no done pulse.
  - A subsequent len=1 copy completes normally.
- Unaligned addresses and back-to-back commands: cmd_src=0x103, cmd_dst=0x2FE, cmd_len=1.
  - HADDR shows 0x100, then 0x2FC.
  - A second command presented on the done cycle is accepted in the following cycle.
